// File: rtl/rx_pkg.sv
// Shared types and helpers for the rx gate packer.
package rx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HEADER = 2'd2} state_t;

  localparam logic [3:0] HDR_MAGIC = 4'hA;

  // Zero channels still produces one word per sample set.
  function automatic logic [15:0] clamp_channels(input logic [15:0] ch, input logic [15:0] max_ch);
    if (ch == 16'd0) return 16'd1;
    if (ch > max_ch) return max_ch;
    return ch;
  endfunction
endpackage

// File: rtl/rx_sc_ram.sv
// Simple dual-port single-clock RAM with a registered, resettable read port.
module rx_sc_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clock or posedge reset)
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (re)  q <= mem[raddr];
endmodule

// File: rtl/rx_gate_packer.sv
// Gate-windowed multi-channel sampler packing sample sets into a circular word buffer.
// Optional per-gate header word: define RX_GATE_HEADER_EN.
module rx_gate_packer
  import rx_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int MAX_CH       = 8,
  parameter int CH_W         = 4,
  parameter int DEPTH_LOG2   = 12,
  parameter int PACKET_WORDS = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     bus_reset,
  input  logic                     strobe,
  input  logic                     gate_enable,
  input  logic [CH_W-1:0]          channels,
  input  logic [MAX_CH*DATA_W-1:0] din,
  input  logic                     rd_req,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     packet_rdy,
  output logic [DEPTH_LOG2:0]      fill_level,
  output logic                     overflow,
  output logic                     overrun,
  input  logic                     clear_status
);
  localparam int FW = DEPTH_LOG2 + 1;
  localparam logic [FW-1:0] DEPTH = FW'(2**DEPTH_LOG2);
  localparam logic [FW-1:0] PKT   = FW'(PACKET_WORDS);

  state_t                        state;
  logic                          gate_prev, gate_rise, strobe_acc, pop, wr_en;
  logic                          accept, ovf_set, ovr_set, hdr_go;
  logic [CH_W-1:0]               nch, nch_c, nch_eff, rem;
  logic [MAX_CH-1:0][DATA_W-1:0] shadow;
  logic [DEPTH_LOG2-1:0]         wr_ptr, rd_ptr;
  logic [DATA_W-1:0]             wr_data;
  logic [FW-1:0]                 space, fill_next;

`ifdef RX_GATE_HEADER_EN
  logic              hdr_pend;
  logic [DATA_W-9:0] gate_cnt;
  logic [DATA_W-1:0] hdr_word;
  assign hdr_word = {HDR_MAGIC, 4'(nch), gate_cnt};
  assign hdr_go   = gate_rise | hdr_pend;

  // A gate edge seen mid-set is remembered so its header follows the set.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      hdr_pend <= 1'b0;
      gate_cnt <= '0;
    end else if (bus_reset) begin
      hdr_pend <= 1'b0;
      gate_cnt <= '0;
    end else begin
      if (state == IDLE && hdr_go) hdr_pend <= 1'b0;
      else if (gate_rise)          hdr_pend <= 1'b1;
      if (state == HEADER) gate_cnt <= gate_cnt + (DATA_W-8)'(1);
    end
`else
  assign hdr_go = 1'b0;
`endif

  assign gate_rise  = gate_enable & ~gate_prev;
  assign strobe_acc = strobe & gate_enable;
  assign nch_c      = CH_W'(clamp_channels(16'(channels), 16'(MAX_CH)));
  assign nch_eff    = gate_rise ? nch_c : nch;
  assign space      = DEPTH - fill_level;
  assign pop        = rd_req & (fill_level != '0);

  always_comb begin
    accept  = 1'b0;
    ovf_set = 1'b0;
    ovr_set = 1'b0;
    wr_en   = 1'b0;
    wr_data = shadow[0];
    case (state)
      IDLE:
        if (hdr_go) ovr_set = strobe_acc;
        else if (strobe_acc) begin
          // Whole set reserved up front; partial sets are never written.
          if (32'(space) >= 32'(nch_eff)) accept = 1'b1;
          else                            ovf_set = 1'b1;
        end
      SHIFT: begin
        wr_en   = 1'b1;
        ovr_set = strobe_acc;
      end
      HEADER: begin
        ovr_set = strobe_acc;
`ifdef RX_GATE_HEADER_EN
        wr_data = hdr_word;
`endif
        if (space != '0) wr_en = 1'b1;
        else             ovf_set = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= IDLE;
      gate_prev <= 1'b0;
      nch       <= CH_W'(1);
      rem       <= '0;
      shadow    <= '0;
      overflow  <= 1'b0;
      overrun   <= 1'b0;
    end else if (bus_reset) begin
      state     <= IDLE;
      gate_prev <= 1'b0;
      nch       <= CH_W'(1);
      rem       <= '0;
      shadow    <= '0;
      overflow  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      gate_prev <= gate_enable;
      if (gate_rise) nch <= nch_c;
      case (state)
        IDLE:
          if (hdr_go) state <= HEADER;
          else if (accept) begin
            shadow <= din;
            rem    <= nch_eff - CH_W'(1);
            state  <= SHIFT;
          end
        SHIFT: begin
          shadow <= shadow >> DATA_W;
          rem    <= rem - CH_W'(1);
          if (rem == '0) state <= IDLE;
        end
        HEADER:  state <= IDLE;
        default: state <= IDLE;
      endcase
      overflow <= ovf_set | (overflow & ~clear_status);
      overrun  <= ovr_set | (overrun & ~clear_status);
    end

  always_comb fill_next = fill_level + FW'(wr_en) - FW'(pop);

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      packet_rdy <= 1'b0;
      dout_valid <= 1'b0;
    end else if (bus_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      packet_rdy <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)   rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      fill_level <= fill_next;
      packet_rdy <= (fill_next >= PKT);
      dout_valid <= pop;
    end

  rx_sc_ram #(.DATA_W(DATA_W), .ADDR_W(DEPTH_LOG2)) u_ram (
    .clock (clock),
    .reset (reset),
    .clr   (bus_reset),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (pop),
    .raddr (rd_ptr),
    .q     (dout)
  );
endmodule

// File: tb/tb_rx_gate_packer.sv
// Directed bench for rx_gate_packer (small buffer, 8-word packets).
module tb_rx_gate_packer;
  localparam int DATA_W = 16, MAX_CH = 8, CH_W = 4, DEPTH_LOG2 = 4, PACKET_WORDS = 8;
`ifdef RX_GATE_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic                     clock = 1'b0, reset = 1'b1, bus_reset = 1'b0, strobe = 1'b0;
  logic                     gate_enable = 1'b0, rd_req = 1'b0, clear_status = 1'b0;
  logic [CH_W-1:0]          channels = '0;
  logic [MAX_CH*DATA_W-1:0] din = '0;
  logic [DATA_W-1:0]        dout;
  logic                     dout_valid, packet_rdy, overflow, overrun;
  logic [DEPTH_LOG2:0]      fill_level;

  int n_cmp = 0, n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  rx_gate_packer #(.DATA_W(DATA_W), .MAX_CH(MAX_CH), .CH_W(CH_W),
                   .DEPTH_LOG2(DEPTH_LOG2), .PACKET_WORDS(PACKET_WORDS)) dut (
    .clock(clock), .reset(reset), .bus_reset(bus_reset), .strobe(strobe),
    .gate_enable(gate_enable), .channels(channels), .din(din), .rd_req(rd_req),
    .dout(dout), .dout_valid(dout_valid), .packet_rdy(packet_rdy),
    .fill_level(fill_level), .overflow(overflow), .overrun(overrun),
    .clear_status(clear_status));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  // Sample set n: channel k carries 8*n+k.
  task automatic fire(input int n);
    for (int k = 0; k < MAX_CH; k++) din[k*DATA_W +: DATA_W] = DATA_W'(8*n + k);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  task automatic open_gate(input int ch);
    gate_enable = 1'b0;
    channels    = CH_W'(ch);
    tick();
    gate_enable = 1'b1;
    tick(3);
  endtask

  task automatic drain();
    int f;
    logic [DATA_W-1:0] last;
    f = exp_q.size();
    rd_req = 1'b1;
    for (int i = 0; i < f; i++) begin
      tick();
      chk("pop_valid", 32'(dout_valid), 32'd1);
      chk("pop_data", 32'(dout), 32'(exp_q[i]));
      chk("pop_fill", 32'(fill_level), 32'(f-1-i));
      chk("pop_pkt", 32'(packet_rdy), 32'((f-1-i) >= PACKET_WORDS));
    end
    last = exp_q[f-1];
    tick();
    chk("empty_valid", 32'(dout_valid), 32'd0);
    chk("empty_hold", 32'(dout), 32'(last));
    rd_req = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_pkt", 32'(packet_rdy), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick();

    // Two channels, four sets; packet_rdy rises exactly as fill reaches 8.
    open_gate(2);
    chk("hdr_fill", 32'(fill_level), 32'(HDR));
    if (HDR != 0) exp_q.push_back(16'hA200);
    for (int i = 0; i < 4; i++) begin
      fire(i);
      tick();
      chk("set_fill_a", 32'(fill_level), 32'(2*i + 1 + HDR));
      chk("set_pkt_a", 32'(packet_rdy), 32'((2*i + 1 + HDR) >= PACKET_WORDS));
      tick();
      chk("set_fill_b", 32'(fill_level), 32'(2*i + 2 + HDR));
      chk("set_pkt_b", 32'(packet_rdy), 32'((2*i + 2 + HDR) >= PACKET_WORDS));
      exp_q.push_back(DATA_W'(8*i));
      exp_q.push_back(DATA_W'(8*i + 1));
    end
    gate_enable = 1'b0;
    drain();

    // channels=0 behaves as one channel.
    open_gate(0);
    if (HDR != 0) exp_q.push_back(16'hA101);
    fire(0);
    tick(3);
    chk("ch0_fill", 32'(fill_level), 32'(1 + HDR));
    exp_q.push_back(16'd0);
    drain();

    // channels=12 is clamped to eight.
    open_gate(12);
    if (HDR != 0) exp_q.push_back(16'hA802);
    fire(1);
    tick(9);
    chk("ch12_fill", 32'(fill_level), 32'(8 + HDR));
    for (int k = 0; k < 8; k++) exp_q.push_back(DATA_W'(8 + k));
    drain();

    // Strobe two cycles after an accepted four-channel strobe is an overrun.
    open_gate(4);
    if (HDR != 0) exp_q.push_back(16'hA403);
    fire(2);
    tick();
    fire(3);
    tick(4);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_noovf", 32'(overflow), 32'd0);
    chk("ovr_fill", 32'(fill_level), 32'(4 + HDR));
    for (int k = 0; k < 4; k++) exp_q.push_back(DATA_W'(16 + k));
    drain();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("ovr_clear", 32'(overrun), 32'd0);

    // Three channels into a 16-word buffer: the sixth set does not fit.
    open_gate(3);
    if (HDR != 0) exp_q.push_back(16'hA304);
    for (int i = 0; i < 5; i++) begin
      fire(i);
      tick(3);
      chk("ovf_fill", 32'(fill_level), 32'(3*(i+1) + HDR));
      for (int k = 0; k < 3; k++) exp_q.push_back(DATA_W'(8*i + k));
    end
    chk("ovf_pre", 32'(overflow), 32'd0);
    fire(5);
    tick(3);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_keep_fill", 32'(fill_level), 32'(15 + HDR));
    chk("ovf_pkt", 32'(packet_rdy), 32'd1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);
    // A set event in the same cycle as clear wins.
    clear_status = 1'b1;
    fire(6);
    clear_status = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("ovf_clear2", 32'(overflow), 32'd0);
    gate_enable = 1'b0;
    drain();

    // Async reset in the middle of a set discards it at once.
    open_gate(4);
    fire(3);
    fire(4);
    chk("mid_ovr", 32'(overrun), 32'd1);
    chk("mid_fill", 32'(fill_level), 32'(1 + HDR));
    #2 reset = 1'b1;
    #1;
    chk("arst_fill", 32'(fill_level), 32'd0);
    chk("arst_ovr", 32'(overrun), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_pkt", 32'(packet_rdy), 32'd0);
    chk("arst_valid", 32'(dout_valid), 32'd0);
    chk("arst_dout", 32'(dout), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    tick(3);
    chk("arst_discard", 32'(fill_level), 32'(HDR));
    fire(5);
    tick(4);
    chk("post_rst_fill", 32'(fill_level), 32'(4 + HDR));

    // Synchronous flush.
    bus_reset = 1'b1;
    tick();
    bus_reset = 1'b0;
    chk("brst_fill", 32'(fill_level), 32'd0);
    chk("brst_pkt", 32'(packet_rdy), 32'd0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("brst_empty", 32'(dout_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rx_gate_packer.md
Name: rx_gate_packer

Overview:
- Single-clock, parametrised successor to the rx-path channel FIFO.
- Samples up to MAX_CH parallel channel words on each decimated strobe while the radar gate is open, then serialises them into an internal circular buffer.
- The FX2 side reads the buffer as a word stream, paced by packet_rdy.
- Adds atomic sample-set writes, per-gate channel-count latching, fill-level output, and separate overflow and overrun status.

Parameters:
- DATA_W, 16, channel/output word width (>=16).
- MAX_CH, 8, number of channel inputs.
- CH_W, 4, width of channels port (2**CH_W > MAX_CH).
- DEPTH_LOG2, 12, buffer depth = 2**DEPTH_LOG2 words.
- PACKET_WORDS, 256, words per FX2 packet; packet_rdy threshold (<= depth).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- bus_reset  in  1  synchronous flush.
- strobe  in  1  one-cycle sample strobe.
- gate_enable  in  1  gate window; samples accepted only while high.
- channels  in  CH_W  active channel count.
- din  in  MAX_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
- rd_req  in  1  read request.
- dout  out  DATA_W  read data.
- dout_valid  out  1  dout holds a newly popped word.
- packet_rdy  out  1  fill_level >= PACKET_WORDS.
- fill_level  out  DEPTH_LOG2+1  words stored.
- overflow  out  1  sticky: sample set dropped because buffer lacked space.
- overrun  out  1  sticky: strobe arrived while still serialising.
- clear_status  in  1  clears overflow/overrun.

Behaviour:
- Reset (async) or bus_reset (sync) drives outputs as follows:
  - dout=0, dout_valid=0, packet_rdy=0, fill_level=0, overflow=0, overrun=0.
  - Pointers 0, FSM IDLE, gate counter 0.
  - Reset mid-serialisation discards the partial set.
- Channel count latch:
  - Channel count nch is latched on the gate_enable rising edge, detected by a registered previous value.
  - channels=0 is treated as 1; channels>MAX_CH is clamped to MAX_CH.
  - nch is constant for the whole gate.
- FSM IDLE:
  - On strobe & gate_enable, if free space = depth-fill_level >= nch: latch all din into a shadow register, set idx=0, go SHIFT.
  - Otherwise drop the whole set and set overflow. Partial sets are never written.
- FSM SHIFT:
  - Write shadow[idx] each cycle, idx+1.
  - After idx=nch-1, return to IDLE, so the next strobe is accepted the cycle after the last write.
  - A strobe seen in SHIFT is dropped and sets overrun.
  - Gate fall during SHIFT still completes the set.
- Read side:
  - rd_req with fill_level>0 pops one word. dout and dout_valid are registered, latency 1.
  - rd_req while empty is ignored: dout_valid=0, dout holds its value.
- Buffer accounting:
  - A simultaneous write and pop leaves fill_level unchanged.
  - Pointers wrap modulo depth.
  - Space is reserved at strobe acceptance, so the buffer never overwrites unread data.
- packet_rdy and fill_level are registered and updated the same cycle as pointer updates.
- Status flags: clear_status clears them next cycle; a set event in the same cycle wins over clear.

Optional Feature:
- Macro: RX_GATE_HEADER_EN.
- Defined:
  - On each gate_enable rising edge, FSM passes through a HEADER state.
  - In HEADER it writes one word: {4'hA, nch[3:0], gate_cnt[DATA_W-9:0]}.
  - gate_cnt increments per gate and wraps.
  - If the buffer is full the header is dropped and overflow is set.
  - A strobe during HEADER counts as overrun.
- Undefined: no HEADER state, no gate counter, data only.

Decomposition:
- Package rx_pkg:
  - FSM state enum (IDLE, SHIFT, HEADER).
  - HDR_MAGIC=4'hA.
  - clamp_channels function.
- Sub-module rx_sc_ram:
  - Simple dual-port single-clock RAM, 2**DEPTH_LOG2 x DATA_W.
  - Registered read.

Test Plan:
- Reset, then MAX_CH=8, channels=2, din[k]=8*n+k, 4 strobes in one gate, drain -> dout sequence 0,1,8,9,16,17,24,25 with dout_valid each; fill_level peaks at 8.
- channels=0, then channels=12 in later gates -> 1 word and 8 words per strobe respectively.
- DEPTH_LOG2=4, channels=3, 6 strobes, no reads -> 5 sets stored (fill_level=15), 6th set dropped, overflow=1; clear_status -> overflow=0.
- channels=4, strobes 2 cycles apart -> second strobe dropped, overrun=1, exactly 4 words written.
- PACKET_WORDS=8, channels=2, 4 strobes -> packet_rdy rises the cycle fill_level reaches 8; 1 pop -> packet_rdy=0; rd_req when empty -> dout_valid=0.
- RX_GATE_HEADER_EN, channels=2, two gates of 1 strobe -> words A200,s0,s1,A201,s0',s1'; async reset mid-SHIFT -> fill_level=0 and all flags cleared immediately.
